// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared widths, level type and limits for the LED PWM fader.
package led_pwm_pkg;
    localparam int LED_PWM_BITS_DEF = 4;
    localparam int LED_NUM_DEF      = 8;
    typedef logic [LED_PWM_BITS_DEF-1:0] led_level_t;
    localparam led_level_t LED_LEVEL_MAX = '1;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED's brightness level, fade/snap stepping and PWM compare.
// LED_PWM_FADE_EN selects a one-step-per-period linear fade; otherwise the level snaps to target.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                period_end,
    input  logic                enable,
    output logic                led_out,
    output logic                mismatch
);
    logic [PWM_BITS-1:0] level, level_nxt;

    always_comb begin
`ifdef LED_PWM_FADE_EN
        level_nxt = level < target ? level + PWM_BITS'(1) :
                    level > target ? level - PWM_BITS'(1) : level;
`else
        level_nxt = target;
`endif
    end

    // Level only moves at the period boundary, so the compare never glitches mid-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            level   <= !enable ? '0 : period_end ? level_nxt : level;
            led_out <= enable && (level == '1 || level > pwm_cnt);
        end
    end

    assign mismatch = level != target;
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM brightness and per-LED fading between the PIO LED word and the pins.
// Define LED_PWM_FADE_EN for linear fades; the default build snaps levels at each period end.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS = LED_NUM_DEF,
    parameter int PWM_BITS = LED_PWM_BITS_DEF,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_word,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [NUM_LEDS-1:0] word_q, mismatch;
    logic [15:0]         prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick, period_end;

    assign tick       = prescaler == PRE_MAX;
    assign period_end = tick && pwm_cnt == '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q    <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            word_q    <= led_word;
            prescaler <= !enable || tick ? '0 : prescaler + 16'd1;
            pwm_cnt   <= !enable ? '0 : tick ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .target    (word_q[i] ? brightness : '0),
            .pwm_cnt   (pwm_cnt),
            .period_end(period_end),
            .enable    (enable),
            .led_out   (led_out[i]),
            .mismatch  (mismatch[i])
        );
    end

    assign busy = |mismatch;
endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream consumer of the 8-bit LED PIO output word; drives the board LED pins.
- Adds global PWM brightness control and per-LED linear fade-in/fade-out on every bit change.
- Removes hard on/off steps so the bathysphere status LEDs ramp smoothly.
- Sits between the PIO out_port and the top-level LED pins, in the same clk domain.

Parameters:
- NUM_LEDS, 8, number of LED channels; equals the PIO word width.
- PWM_BITS, 4, width of the brightness, level and PWM counter; one period is 2^PWM_BITS ticks.
- PRESCALE, 50, clk cycles per PWM tick; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- led_word  in  NUM_LEDS  LED on/off request, from PIO out_port.
- brightness  in  PWM_BITS  global target level for LEDs that are on.
- enable  in  1  master enable; low forces all LEDs dark.
- led_out  out  NUM_LEDS  PWM-modulated LED pin drive, registered.
- busy  out  1  high while any channel level differs from its target.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All of the following clear to 0: word_q, prescaler, pwm_cnt, every level[i] and led_out. busy is 0 while in reset.
- Input stage: led_word is registered into word_q every cycle. A change appears in target one cycle later.
- target[i] = word_q[i] ? brightness : 0. This is combinational and re-evaluated every cycle, so a brightness change mid-fade redirects the fade immediately.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted in the cycle it equals PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- PWM counter:
  - pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0.
  - period_end = tick && pwm_cnt == all-ones.
- Level update, on period_end only:
  - level[i] < target[i]: level[i] increments by 1.
  - level[i] > target[i]: level[i] decrements by 1.
  - Otherwise level[i] holds.
  - A full fade 0 to 15 takes 15 periods.
- Compare:
  - led_out[i] is registered as enable && (level[i] == all-ones || level[i] > pwm_cnt).
  - Level L gives duty L/16, except all-ones, which is always on.
  - Level 0 is always off.
- busy is combinational: OR over i of (level[i] != target[i]). No glitch on led_out during level updates, because level changes only at the period boundary.
- Enable low:
  - prescaler, pwm_cnt and all levels are held at 0.
  - led_out is 0 on the next clk edge.
  - busy reflects target versus level (0) and stays asserted for any LED requested on.
  - On re-enable, channels fade up from 0.
- Simultaneous events: a word change in the same cycle as period_end uses the old target for that update, because word_q lags by one cycle.
- Reset mid-fade: all state is cleared immediately (asynchronous). No resume.

Optional Feature:
- Macro: LED_PWM_FADE_EN.
- Defined: linear fade as described above.
- Undefined:
  - On period_end, level[i] loads target[i] directly (snap).
  - busy is high from the target change until the next period_end.
  - Duty behaviour is otherwise unchanged.

Decomposition:
- Package led_pwm_pkg:
  - LED_PWM_BITS_DEF = 4
  - LED_NUM_DEF = 8
  - typedef led_level_t, logic [PWM_BITS-1:0]
  - LED_LEVEL_MAX = all-ones
- Sub-module led_pwm_channel, one instance per LED, generated NUM_LEDS times.
  - Contains the level register, step/snap logic, compare and output flop.
  - Inputs: target, pwm_cnt, period_end, enable.
  - Outputs: led_out bit, mismatch bit.
- Top level holds the input register, prescaler, PWM counter and busy OR-reduction.

Test Plan (PRESCALE=2, PWM_BITS=4, so one period = 32 clk):
- Reset asserted mid-run with led_word=0xFF → led_out=0x00 and busy=0 immediately; both stay 0 for 2 cycles after release if led_word=0x00.
- enable=1, brightness=15, led_word 0x00→0x01 → busy=1 two cycles later; level[0] reaches 15 after 15 period_ends; led_out[0] is constant 1 and busy falls in the same cycle.
- brightness=8, LED 0 settled at level 8 → led_out[0] high exactly 16 of every 32 cycles, and high in the cycles where pwm_cnt is 0..7.
- LED 0 at level 15, brightness changed to 4 → level steps down one per period to 4 (11 periods); duty ends at 8/32 cycles.
- Mid-fade, enable dropped → led_out=0x00 on next edge and busy stays 1; enable restored → fade restarts from level 0.
- led_word=0xFF, brightness=0 → led_out stays 0x00 and busy=0. With LED_PWM_FADE_EN undefined and brightness=15, level jumps to 15 at the first period_end.
